// File: rtl/regfile_wb_arbiter.sv
// Write-side arbiter for the 32x32 register file: merges pipeline writeback with a
// buffered multi-cycle result stream and tracks registers owned by in-flight multi-cycle ops.
module regfile_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        mc_valid,
   output logic        mc_ready,
   input  logic [4:0]  mc_addr,
   input  logic [31:0] mc_data,
   input  logic        mc_issue,
   input  logic [4:0]  mc_issue_addr,
   input  logic [4:0]  chk_addr1,
   input  logic [4:0]  chk_addr2,
   output logic        stall_req,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   output logic [31:0] pend_mask,
   output logic        hazard_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t           fifo_mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] starve_cnt;

   logic        empty, full, mc_xfer, starve, wb_win;
   logic        push, pop, win_we, mc_commit;
   logic [4:0]  win_addr;
   logic [31:0] win_data;
   logic [31:0] set_mask, clr_mask;
   logic        issue_dup, waw;
   wr_t         head;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign mc_ready = !full && !reset;
   assign mc_xfer  = mc_valid && mc_ready;
   assign head     = fifo_mem[rd_ptr];
   // A starved head takes the slot: wb is ignored while the pipeline is stalled.
   assign starve   = !empty && (starve_cnt == SW'(STARVE_LIMIT));
   assign wb_win   = wb_we && (wb_addr != 5'd0) && !starve;

   // NOTE: every output of this block gets a default first so no path leaves a latch.
   always_comb begin
      push      = 1'b0;
      pop       = 1'b0;
      win_we    = 1'b0;
      win_addr  = 5'd0;
      win_data  = 32'd0;
      mc_commit = 1'b0;
      if (wb_win) begin
         win_we   = 1'b1;
         win_addr = wb_addr;
         win_data = wb_data;
         push     = mc_xfer;
      end else if (!empty) begin
         pop       = 1'b1;
         push      = mc_xfer;
         win_we    = (head.addr != 5'd0);
         win_addr  = head.addr;
         win_data  = head.data;
         mc_commit = win_we;
      end else if (mc_xfer) begin
         win_we    = (mc_addr != 5'd0);
         win_addr  = mc_addr;
         win_data  = mc_data;
         mc_commit = win_we;
      end
   end

   assign set_mask  = (mc_issue && mc_issue_addr != 5'd0) ? (32'd1 << mc_issue_addr) : 32'd0;
   assign clr_mask  = mc_commit ? (32'd1 << win_addr) : 32'd0;
   assign issue_dup = mc_issue && (mc_issue_addr != 5'd0) && pend_mask[mc_issue_addr];
   assign waw       = wb_win && pend_mask[wb_addr];

   // No bypass of the write in flight, so the pending bit keeps stalling through its commit cycle.
   assign stall_req = ((chk_addr1 != 5'd0) && pend_mask[chk_addr1]) ||
                      ((chk_addr2 != 5'd0) && pend_mask[chk_addr2]) || starve;

   // NOTE: storage is qualified by count/pointers, so the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{addr: mc_addr, data: mc_data};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         rf_we      <= 1'b0;
         rf_addr    <= 5'd0;
         rf_data    <= 32'd0;
         pend_mask  <= 32'd0;
         hazard_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         starve_cnt <= (!empty && wb_win) ? starve_cnt + 1'b1 : '0;
         rf_we      <= win_we;
         rf_addr    <= win_addr;
         rf_data    <= win_data;
         pend_mask  <= (pend_mask & ~clr_mask) | set_mask;
         if (issue_dup || waw) hazard_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected writes in commit order,
// an independent monitor compares every rf_we pulse against the queue head.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we, mc_valid, mc_ready, mc_issue;
   logic [4:0]  wb_addr, mc_addr, mc_issue_addr, chk_addr1, chk_addr2;
   logic [31:0] wb_data, mc_data;
   logic        stall_req, rf_we, hazard_err;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data, pend_mask;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
      .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .stall_req(stall_req), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
      .pend_mask(pend_mask), .hazard_err(hazard_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back('{addr: a, data: d});
   endtask

   // Drive point just after the rising edge; check point at the following falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
      wb_we = we; wb_addr = a; wb_data = d;
   endtask

   task automatic set_mc(input logic v, input logic [4:0] a, input logic [31:0] d);
      mc_valid = v; mc_addr = a; mc_data = d;
   endtask

   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, want no write", rf_addr, rf_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(rf_addr), 32'(mon_e.addr));
            check("wr_data", rf_data, mon_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, want finish before 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      set_wb(0, 0, 0);
      set_mc(0, 0, 0);
      mc_issue = 0; mc_issue_addr = 0; chk_addr1 = 0; chk_addr2 = 0;

      // Reset, then a plain writeback.
      cyc(); mid();
      check("rst_rf_we", 32'(rf_we), 0);
      check("rst_rf_addr", 32'(rf_addr), 0);
      check("rst_rf_data", rf_data, 0);
      check("rst_pend", pend_mask, 0);
      check("rst_hazard", 32'(hazard_err), 0);
      check("rst_mc_ready", 32'(mc_ready), 0);
      cyc();
      reset = 1'b0;
      set_wb(1, 3, 32'h11); expect_wr(3, 32'h11);
      mid(); check("ready_after_rst", 32'(mc_ready), 1);

      // Flow-through of an mc result with an empty FIFO.
      cyc(); set_wb(0, 0, 0);
      set_mc(1, 7, 32'hABCD); expect_wr(7, 32'hABCD);
      mid(); check("flow_ready", 32'(mc_ready), 1);

      // Conflict: wb wins, mc result buffered and drained next cycle.
      cyc(); set_wb(1, 2, 32'h22); set_mc(1, 5, 32'h55);
      expect_wr(2, 32'h22); expect_wr(5, 32'h55);
      cyc(); set_wb(0, 0, 0); set_mc(0, 0, 0);
      mid(); check("one_buffered_ready", 32'(mc_ready), 1);

      // Fill to DEPTH under continuous wb, hold a third result, drain with push+pop.
      cyc(); set_wb(1, 4, 32'h44); set_mc(1, 6, 32'h66); expect_wr(4, 32'h44);
      cyc(); set_wb(1, 10, 32'hA0); set_mc(1, 11, 32'hB1); expect_wr(10, 32'hA0);
      cyc(); set_wb(1, 13, 32'hD0); set_mc(1, 14, 32'hE4); expect_wr(13, 32'hD0);
      mid(); check("full_ready", 32'(mc_ready), 0);
      cyc(); set_wb(0, 0, 0); expect_wr(6, 32'h66);
      mid(); check("full_still", 32'(mc_ready), 0);
      cyc(); expect_wr(11, 32'hB1); expect_wr(14, 32'hE4);
      mid(); check("pushpop_ready", 32'(mc_ready), 1);
      cyc(); set_mc(0, 0, 0);
      mid(); check("drain_ready", 32'(mc_ready), 1);

      // Starvation: one entry (addr 9) behind continuous wb.
      cyc(); set_wb(1, 1, 32'h100); set_mc(1, 9, 32'h99); expect_wr(1, 32'h100);
      cyc(); set_mc(0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         set_wb(1, 1, 32'h100 + 32'(i)); expect_wr(1, 32'h100 + 32'(i));
         mid(); check("starve_pre", 32'(stall_req), 0);
         cyc();
      end
      set_wb(1, 1, 32'hDEAD); expect_wr(9, 32'h99);
      mid(); check("starve_stall", 32'(stall_req), 1);
      cyc(); set_wb(1, 1, 32'h106); expect_wr(1, 32'h106);
      mid(); check("starve_cleared", 32'(stall_req), 0);
      cyc(); set_wb(0, 0, 0);

      // Scoreboard stall on a pending source register.
      mc_issue = 1; mc_issue_addr = 12;
      mid(); check("sb_no_stall", 32'(stall_req), 0);
      cyc(); mc_issue = 0; chk_addr1 = 12;
      mid(); check("sb_pend_set", pend_mask, 32'h0000_1000);
      check("sb_stall1", 32'(stall_req), 1);
      cyc();
      mid(); check("sb_stall2", 32'(stall_req), 1);
      cyc(); set_mc(1, 12, 32'hC12); expect_wr(12, 32'hC12);
      mid(); check("sb_stall_commit", 32'(stall_req), 1);
      check("sb_pend_commit", pend_mask, 32'h0000_1000);
      cyc(); set_mc(0, 0, 0);
      mid(); check("sb_pend_clr", pend_mask, 0);
      check("sb_stall_off", 32'(stall_req), 0);
      cyc(); chk_addr1 = 0;

      // Reset mid-operation discards a buffered result and a pending bit.
      set_wb(1, 3, 32'h33); set_mc(1, 20, 32'h2020); expect_wr(3, 32'h33);
      mc_issue = 1; mc_issue_addr = 20;
      cyc(); reset = 1; set_wb(0, 0, 0); set_mc(0, 0, 0); mc_issue = 0;
      cyc();
      mid(); check("midrst_pend", pend_mask, 0);
      check("midrst_ready", 32'(mc_ready), 0);
      cyc(); reset = 0;
      mid(); check("midrst_hazard", 32'(hazard_err), 0);
      check("midrst_ready1", 32'(mc_ready), 1);
      cyc();

      // Double issue is a sticky error; chk addr 0 never stalls.
      mc_issue = 1; mc_issue_addr = 12;
      cyc();
      mid(); check("dup_hazard_pre", 32'(hazard_err), 0);
      check("chk0_no_stall", 32'(stall_req), 0);
      cyc(); mc_issue = 0;
      mid(); check("dup_hazard", 32'(hazard_err), 1);
      cyc(); reset = 1;
      cyc(); cyc(); reset = 0;
      mid(); check("hazard_rst", 32'(hazard_err), 0);

      // WAW: wb to a pending register flags the error but still writes.
      cyc(); mc_issue = 1; mc_issue_addr = 12;
      cyc(); mc_issue = 0; set_wb(1, 12, 32'hFA); expect_wr(12, 32'hFA);
      mid(); check("waw_pre", 32'(hazard_err), 0);
      cyc(); set_wb(0, 0, 0);
      mid(); check("waw_hazard", 32'(hazard_err), 1);
      check("waw_pend_kept", pend_mask, 32'h0000_1000);

      // Address 0 on every source: no write, no pending bit.
      cyc(); set_wb(1, 0, 32'h77); set_mc(1, 0, 32'h88); mc_issue = 1; mc_issue_addr = 0;
      cyc(); mc_issue = 0; set_wb(1, 3, 32'h33); set_mc(1, 0, 32'h99); expect_wr(3, 32'h33);
      cyc(); set_wb(0, 0, 0); set_mc(0, 0, 0);
      mid(); check("x0_pend", pend_mask, 32'h0000_1000);
      cyc(); cyc();
      mid(); check("hazard_sticky", 32'(hazard_err), 1);
      check("x0_ready", 32'(mc_ready), 1);
      cyc(); cyc();
      mid(); check("exp_q_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
